hub75_panel_receiver: RTL and testbench
=======================================

Name: hub75_panel_receiver

Overview:
- Behavioural receiver for the LED-matrix shift interface: the panel end of the serial link driven by the column-fill and row-scan logic.
- Samples LED1/LED2 colour bits on each sclk rising edge and on each latch rising edge commits the shifted row pair into an internal frame store.
- Exposes a registered read port and protocol-error flags.
- Used as a synthesizable panel model in system benches and as an on-FPGA protocol checker.

Parameters:
- COLS, 32, pixels per row (shift-register length).
- ROWS, 32, total panel rows; each latch writes row addr and row addr+ROWS/2.
- ADDR_W, $clog2(ROWS/2), row-address width (derived, not overridden).

Ports:
- clk  input  1  system clock; sclk, lat and data are synchronous to it.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  panel shift clock, level signal; rising edge detected in clk domain.
- LED1  input  3  {R,G,B} for the upper-half row, sampled on sclk rise.
- LED2  input  3  {R,G,B} for the lower-half row, sampled on sclk rise.
- lat  input  1  latch strobe; rising edge commits the shift register.
- oe_n  input  1  output enable, active low; only tracked for blank counting.
- addr  input  ADDR_W  row-pair address, sampled on lat rise.
- rd_row  input  $clog2(ROWS)  read row.
- rd_col  input  $clog2(COLS)  read column.
- rd_data  output  3  stored pixel, 1-cycle latency.
- shift_count  output  $clog2(COLS)+1  sclk rises since last latch, saturating at COLS+1.
- latch_ok  output  1  one-cycle pulse on a valid commit.
- err_short  output  1  sticky: latch with shift_count < COLS.
- err_long  output  1  sticky: latch with shift_count > COLS.
- frame_done  output  1  one-cycle pulse when a valid commit hits addr == ROWS/2-1.
- blank_cycles  output  16  clk cycles with oe_n high, saturating at 16'hFFFF.

Behaviour:
- Reset: all outputs 0; shift register, frame store, sclk_q and lat_q cleared to 0.
- Edges:
  - sclk_rise = sclk & ~sclk_q.
  - lat_rise = lat & ~lat_q.
  - sclk_q and lat_q update every cycle.
  - The first cycle after reset cannot produce an edge if the input is already high.
- Shift: on sclk_rise the pixel pair {LED1,LED2} enters position 0 and existing entries move up one.
  - After COLS shifts, the first-shifted pixel sits at column COLS-1 and the last at column 0.
  - shift_count increments, saturating at COLS+1.
- Commit on lat_rise, evaluated against the pre-edge shift_count:
  - == COLS: copy LED1 lane to row addr and LED2 lane to row addr+ROWS/2. Pulse latch_ok. Pulse frame_done if addr == ROWS/2-1.
  - < COLS: set err_short; frame store unchanged.
  - > COLS: set err_long; frame store unchanged.
  - shift_count returns to 0 in all three cases.
- Simultaneous sclk_rise and lat_rise:
  - Commit decision and data use pre-shift contents and count.
  - The new pixel is then shifted in and shift_count becomes 1.
- Shift register contents are not cleared by latch; only shift_count is.
- Error flags are sticky until reset.
- Read: rd_data <= store[rd_row][rd_col] every cycle. A read of a row committed in the same cycle returns old data; new data is visible one cycle later.
- blank_cycles increments each cycle oe_n==1, saturating; it has no effect on the store.
- Reset mid-row: discards partial shifts. A later latch with fewer than COLS fresh shifts raises err_short.

Decomposition:
- Package hub75_pkg:
  - pixel_t (3-bit packed {r,g,b}).
  - pixel_pair_t {pixel_t upper, lower}.
  - Constants PANEL_COLS=32 and PANEL_ROWS=32, used as parameter defaults.
- Sub-module rise_detect (clk, reset, in, rise), instantiated for sclk and lat.
- Frame store and shift register are inline register arrays.

Test Plan:
- Reset: assert reset 3 cycles with sclk=1, lat=1 → all outputs 0, rd_data=0 at every address, no edge detected on release.
- Full row:
  - Stimulus: 32 sclk pulses with LED1=col mod 8, LED2=7-(col mod 8), then lat pulse with addr=3.
  - Response: latch_ok for one cycle.
  - Reading row 3 gives column 31 = 0 and column 0 = 7; row 19 gives the complement pattern; err flags stay 0.
- Short/long rows:
  - 31 shifts then latch → err_short=1, store unchanged, shift_count=0.
  - 40 shifts → shift_count saturates at 33; latch → err_long=1.
- Frame end: valid 32-shift commit at addr=15 → frame_done high exactly one cycle, coincident with latch_ok. addr=14 → no frame_done.
- Simultaneous edges: 32 shifts, then sclk and lat rise in the same cycle → valid commit of the 32 pre-shift pixels, shift_count=1 afterwards.
- Reset mid-row / blanking:
  - 20 shifts, reset, 10 shifts, latch → err_short.
  - oe_n high for 100 cycles → blank_cycles=100.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared pixel types and default panel geometry for the HUB75 panel receiver.
package hub75_pkg;

  localparam int PANEL_COLS = 32;
  localparam int PANEL_ROWS = 32;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } pixel_t;

  typedef struct packed {
    pixel_t upper;
    pixel_t lower;
  } pixel_pair_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input synchronous to clk.
// Stays quiet for the first cycle after reset so an already-high input is not reported as an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic rise_o
);

  logic in_q;
  logic armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      in_q    <= in_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = in_i & ~in_q & armed_q;

endmodule

// File: rtl/hub75_panel_receiver.sv
// Panel end of a HUB75 link: shifts colour pairs on sclk rise, commits a row pair on lat rise,
// exposes a 1-cycle registered read port, shift/blank counters and sticky protocol-error flags.
module hub75_panel_receiver
  import hub75_pkg::*;
#(
  parameter  int COLS   = PANEL_COLS,
  parameter  int ROWS   = PANEL_ROWS,
  localparam int ADDR_W = $clog2(ROWS/2),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int COL_W  = $clog2(COLS),
  localparam int CNT_W  = COL_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic [2:0]        LED1,
  input  logic [2:0]        LED2,
  input  logic              lat,
  input  logic              oe_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [2:0]        rd_data,
  output logic [CNT_W-1:0]  shift_count,
  output logic              latch_ok,
  output logic              err_short,
  output logic              err_long,
  output logic              frame_done,
  output logic [15:0]       blank_cycles
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COLS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(COLS + 1);

  logic sclk_rise;
  logic lat_rise;

  rise_detect u_sclk_rise (.clk(clk), .reset(reset), .in_i(sclk), .rise_o(sclk_rise));
  rise_detect u_lat_rise  (.clk(clk), .reset(reset), .in_i(lat),  .rise_o(lat_rise));

  pixel_pair_t      sr_q    [COLS];
  pixel_t           store_q [ROWS][COLS];
  pixel_t           rd_data_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      blank_q, blank_d;
  logic             latch_ok_q, frame_done_q, err_short_q, err_long_q;

  logic             commit;
  logic [ROW_W-1:0] row_up, row_dn;

  assign commit = lat_rise && (cnt_q == CNT_FULL);
  assign row_up = ROW_W'(addr);
  assign row_dn = ROW_W'(addr) + ROW_W'(ROWS/2);

  // A latch restarts the count; a coincident sclk rise is the first shift of the next row.
  always_comb begin
    cnt_d = cnt_q;
    if (lat_rise) begin
      cnt_d = sclk_rise ? CNT_W'(1) : '0;
    end else if (sclk_rise && cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    blank_d = blank_q;
    if (oe_n && blank_q != 16'hFFFF) begin
      blank_d = blank_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COLS; i++) begin
        sr_q[i] <= '0;
      end
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          store_q[r][c] <= '0;
        end
      end
      rd_data_q    <= '0;
      cnt_q        <= '0;
      blank_q      <= '0;
      latch_ok_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      blank_q      <= blank_d;
      latch_ok_q   <= commit;
      frame_done_q <= commit && (addr == ADDR_W'(ROWS/2 - 1));
      err_short_q  <= err_short_q | (lat_rise && cnt_q < CNT_FULL);
      err_long_q   <= err_long_q  | (lat_rise && cnt_q > CNT_FULL);
      rd_data_q    <= store_q[rd_row][rd_col];
      if (sclk_rise) begin
        sr_q[0] <= {LED1, LED2};
        for (int i = 1; i < COLS; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
      // Commit reads the pre-shift register, so a coincident shift never leaks in.
      if (commit) begin
        for (int c = 0; c < COLS; c++) begin
          store_q[row_up][c] <= sr_q[c].upper;
          store_q[row_dn][c] <= sr_q[c].lower;
        end
      end
    end
  end

  assign rd_data      = rd_data_q;
  assign shift_count  = cnt_q;
  assign latch_ok     = latch_ok_q;
  assign frame_done   = frame_done_q;
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;
  assign blank_cycles = blank_q;

endmodule

// File: tb/tb_hub75_panel_receiver.sv
// Self-checking bench for hub75_panel_receiver: directed scenarios plus randomized rows,
// compared every cycle against a row-level reference model.
module tb_hub75_panel_receiver;

  localparam int COLS = 32;
  localparam int ROWS = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic [2:0] LED1 = 3'd0;
  logic [2:0] LED2 = 3'd0;
  logic       lat = 1'b0;
  logic       oe_n = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [4:0] rd_row = 5'd0;
  logic [4:0] rd_col = 5'd0;
  logic [2:0] rd_data;
  logic [5:0] shift_count;
  logic       latch_ok, err_short, err_long, frame_done;
  logic [15:0] blank_cycles;

  always #5 clk = ~clk;

  hub75_panel_receiver dut (
    .clk(clk), .reset(reset), .sclk(sclk), .LED1(LED1), .LED2(LED2), .lat(lat),
    .oe_n(oe_n), .addr(addr), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .shift_count(shift_count), .latch_ok(latch_ok), .err_short(err_short),
    .err_long(err_long), .frame_done(frame_done), .blank_cycles(blank_cycles)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the panel's row/pixel state, tracked per clock.
  logic [2:0]  m_store [ROWS][COLS];
  logic [5:0]  m_pairs [$];
  int          m_fresh = 0;
  int          m_blank = 0;
  logic        m_prev_s = 1'b0, m_prev_l = 1'b0, m_first = 1'b1;
  logic        m_ok = 1'b0, m_fd = 1'b0, m_es = 1'b0, m_el = 1'b0;
  logic [2:0]  m_rd = 3'd0;
  logic        m_live = 1'b0;

  always @(posedge clk) begin : model
    logic s_r, l_r;
    logic [5:0] pr;
    if (reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) m_store[r][c] = 3'd0;
      m_pairs = {};
      for (int i = 0; i < COLS; i++) m_pairs.push_back(6'd0);
      m_fresh = 0; m_blank = 0; m_first = 1'b1;
      m_ok = 1'b0; m_fd = 1'b0; m_es = 1'b0; m_el = 1'b0; m_rd = 3'd0;
    end else begin
      s_r = sclk && !m_prev_s && !m_first;
      l_r = lat && !m_prev_l && !m_first;
      m_rd = m_store[rd_row][rd_col];
      m_ok = 1'b0;
      m_fd = 1'b0;
      if (l_r) begin
        if (m_fresh == COLS) begin
          // the most recently shifted pixel lands in column 0
          for (int c = 0; c < COLS; c++) begin
            pr = m_pairs[m_pairs.size() - 1 - c];
            m_store[addr][c] = pr[5:3];
            m_store[addr + ROWS/2][c] = pr[2:0];
          end
          m_ok = 1'b1;
          m_fd = (addr == ROWS/2 - 1);
        end else if (m_fresh < COLS) begin
          m_es = 1'b1;
        end else begin
          m_el = 1'b1;
        end
        m_fresh = 0;
      end
      if (s_r) begin
        m_pairs.push_back({LED1, LED2});
        if (m_pairs.size() > COLS) void'(m_pairs.pop_front());
        if (m_fresh < COLS + 1) m_fresh++;
      end
      if (oe_n && m_blank < 65535) m_blank++;
      m_first = 1'b0;
    end
    m_prev_s = sclk;
    m_prev_l = lat;
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("cyc_rd_data", rd_data, m_rd);
      chk("cyc_shift_count", shift_count, m_fresh);
      chk("cyc_latch_ok", latch_ok, m_ok);
      chk("cyc_frame_done", frame_done, m_fd);
      chk("cyc_err_short", err_short, m_es);
      chk("cyc_err_long", err_long, m_el);
      chk("cyc_blank", blank_cycles, m_blank);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rstep();
    rd_row = 5'($urandom_range(0, ROWS-1));
    rd_col = 5'($urandom_range(0, COLS-1));
    oe_n   = 1'($urandom_range(0, 1));
    step();
  endtask

  task automatic shift(input logic [2:0] u, input logic [2:0] l);
    LED1 = u; LED2 = l; sclk = 1'b1;
    step();
    sclk = 1'b0;
    step();
  endtask

  task automatic rshift();
    LED1 = 3'($urandom_range(0, 7));
    LED2 = 3'($urandom_range(0, 7));
    sclk = 1'b1;
    repeat ($urandom_range(1, 2)) rstep();
    sclk = 1'b0;
    repeat ($urandom_range(1, 2)) rstep();
  endtask

  task automatic pattern_row();
    for (int col = 0; col < COLS; col++) shift(3'(col % 8), 3'(7 - col % 8));
  endtask

  task automatic latch(input logic [3:0] a, output logic ok1, output logic fd1,
                       output logic ok2, output logic fd2);
    addr = a; lat = 1'b1;
    step();
    ok1 = latch_ok; fd1 = frame_done;
    lat = 1'b0;
    step();
    ok2 = latch_ok; fd2 = frame_done;
  endtask

  task automatic read_px(input int r, input int c, input int unsigned exp, input string name);
    rd_row = 5'(r); rd_col = 5'(c);
    step();
    chk(name, rd_data, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok1, fd1, ok2, fd2;
    int n;

    // reset with sclk/lat held high; releasing must not create edges
    reset = 1'b1; sclk = 1'b1; lat = 1'b1;
    repeat (3) step();
    chk("rst_shift_count", shift_count, 0);
    chk("rst_latch_ok", latch_ok, 0);
    chk("rst_blank", blank_cycles, 0);
    reset = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) read_px(r, c, 0, "rst_rd_zero");
    chk("rst_no_sclk_edge", shift_count, 0);
    chk("rst_no_lat_edge", err_short, 0);
    sclk = 1'b0; lat = 1'b0;
    step();

    // full row to addr 3
    pattern_row();
    latch(4'd3, ok1, fd1, ok2, fd2);
    chk("full_latch_ok", ok1, 1);
    chk("full_latch_ok_pulse", ok2, 0);
    chk("full_fd", fd1, 0);
    read_px(3, 31, 0, "row3_col31");
    read_px(3, 0, 7, "row3_col0");
    read_px(3, 10, 5, "row3_col10");
    read_px(19, 31, 7, "row19_col31");
    read_px(19, 0, 0, "row19_col0");
    chk("full_err_short", err_short, 0);
    chk("full_err_long", err_long, 0);

    // frame end
    for (int i = 0; i < COLS; i++) shift(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    latch(4'd15, ok1, fd1, ok2, fd2);
    chk("f15_latch_ok", ok1, 1);
    chk("f15_frame_done", fd1, 1);
    chk("f15_frame_done_pulse", fd2, 0);
    for (int i = 0; i < COLS; i++) shift(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    latch(4'd14, ok1, fd1, ok2, fd2);
    chk("f14_latch_ok", ok1, 1);
    chk("f14_frame_done", fd1, 0);

    // short row must leave row 3 untouched
    for (int i = 0; i < COLS - 1; i++) shift(3'd2, 3'd2);
    latch(4'd3, ok1, fd1, ok2, fd2);
    chk("short_latch_ok", ok1, 0);
    chk("short_err_short", err_short, 1);
    chk("short_err_long", err_long, 0);
    chk("short_count_clear", shift_count, 0);
    read_px(3, 0, 7, "short_row3_keep");

    // long row saturates the counter
    for (int i = 0; i < 40; i++) shift(3'd1, 3'd6);
    chk("long_count_sat", shift_count, 33);
    latch(4'd4, ok1, fd1, ok2, fd2);
    chk("long_latch_ok", ok1, 0);
    chk("long_err_long", err_long, 1);
    chk("long_count_clear", shift_count, 0);

    // simultaneous sclk and lat rise
    pattern_row();
    LED1 = 3'd5; LED2 = 3'd2; addr = 4'd7; sclk = 1'b1; lat = 1'b1;
    step();
    chk("simul_latch_ok", latch_ok, 1);
    sclk = 1'b0; lat = 1'b0;
    step();
    chk("simul_count_one", shift_count, 1);
    read_px(7, 0, 7, "simul_row7_col0");
    read_px(7, 31, 0, "simul_row7_col31");
    read_px(23, 0, 0, "simul_row23_col0");

    // reset mid-row discards partial shifts
    for (int i = 0; i < 20; i++) shift(3'd3, 3'd4);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("midrst_err_clear", err_short, 0);
    chk("midrst_count", shift_count, 0);
    step();
    for (int i = 0; i < 10; i++) shift(3'd3, 3'd4);
    latch(4'd2, ok1, fd1, ok2, fd2);
    chk("midrst_err_short", err_short, 1);
    chk("midrst_latch_ok", ok1, 0);

    // blanking counter
    reset = 1'b1;
    step();
    reset = 1'b0;
    oe_n = 1'b1;
    repeat (100) step();
    oe_n = 1'b0;
    chk("blank_100", blank_cycles, 100);

    // randomized rows
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 14; k++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(28, 36) : COLS;
      for (int i = 0; i < n; i++) rshift();
      if ($urandom_range(0, 4) == 0) begin
        LED1 = 3'($urandom_range(0, 7)); LED2 = 3'($urandom_range(0, 7));
        addr = 4'($urandom_range(0, 15)); sclk = 1'b1; lat = 1'b1;
        rstep();
        sclk = 1'b0; lat = 1'b0;
        rstep();
      end else begin
        addr = 4'($urandom_range(0, 15)); lat = 1'b1;
        repeat ($urandom_range(1, 2)) rstep();
        lat = 1'b0;
        repeat ($urandom_range(1, 3)) rstep();
      end
    end
    repeat (200) rstep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
